// File: rtl/matmul_seq_mac_if.sv
// Host-side handshake and matrix bus for the sequential MAC matrix multiplier.
// The master drives the request and operands; the slave returns status and the result.
interface matmul_seq_mac_if #(
  parameter int unsigned N  = 2,
  parameter int unsigned DW = 8,
  parameter int unsigned OW = 8
);
  logic                start;
  logic                abort;
  logic [N*N*DW-1:0]   a;
  logic [N*N*DW-1:0]   b;
  logic                busy;
  logic                done;
  logic [N*N*OW-1:0]   res;

  modport master (output start, output abort, output a, output b,
                  input  busy,  input  done,  input  res);
  modport slave  (input  start, input  abort, input  a, input  b,
                  output busy,  output done,  output res);
endinterface

// File: rtl/matmul_seq_mac.sv
// N x N matrix multiplier RES = A * B built around one shared MAC, iterating i, j, k.
// Results are converted (saturate or wrap) per element and published on a one-cycle done pulse.
module matmul_seq_mac #(
  parameter int unsigned N      = 2,
  parameter int unsigned DW     = 8,
  parameter int unsigned OW     = 8,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned SAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  matmul_seq_mac_if.slave   mm
);

  localparam int unsigned ACC_W = 2*DW + $clog2(N);
  localparam int unsigned IW    = $clog2(N);
  localparam int unsigned AW    = N*N*DW;
  localparam int unsigned RW    = N*N*OW;
  localparam logic [IW-1:0] LAST = IW'(N-1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q;
  logic [AW-1:0]     a_q, b_q;
  logic [RW-1:0]     work_q, work_d, res_q;
  logic [IW-1:0]     i_q, j_q, k_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              busy_q, done_q;

  logic [DW-1:0]     a_m [N][N];
  logic [DW-1:0]     b_m [N][N];
  logic [DW-1:0]     a_el, b_el;
  logic [ACC_W-1:0]  op_a, op_b, prod;
  logic [OW-1:0]     elem;

  // Unpack latched operands into element arrays.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign a_m[r][c] = a_q[(r*N+c)*DW +: DW];
      assign b_m[r][c] = b_q[(r*N+c)*DW +: DW];
    end
  end

  // Shared MAC: product formed at full accumulator width after extension.
  always_comb begin
    a_el = a_m[i_q][k_q];
    b_el = b_m[k_q][j_q];
    if (SIGNED != 0) begin
      op_a = ACC_W'($signed(a_el));
      op_b = ACC_W'($signed(b_el));
    end else begin
      op_a = ACC_W'(a_el);
      op_b = ACC_W'(b_el);
    end
    prod  = op_a * op_b;
    acc_d = ((k_q == '0) ? '0 : acc_q) + prod;
  end

  // Accumulator to result element conversion.
  if (OW >= ACC_W) begin : g_ext
    if (SIGNED != 0) begin : g_sext
      assign elem = OW'($signed(acc_d));
    end else begin : g_zext
      assign elem = OW'(acc_d);
    end
  end else if (SAT != 0) begin : g_sat
    localparam logic [ACC_W-1:0] SMAX = {{(ACC_W-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {{(ACC_W-OW+1){1'b1}}, {(OW-1){1'b0}}};
    always_comb begin
      elem = acc_d[OW-1:0];
      if (SIGNED != 0) begin
        if ($signed(acc_d) > $signed(SMAX))      elem = SMAX[OW-1:0];
        else if ($signed(acc_d) < $signed(SMIN)) elem = SMIN[OW-1:0];
      end else if (|acc_d[ACC_W-1:OW]) begin
        elem = '1;
      end
    end
  end else begin : g_wrap
    assign elem = acc_d[OW-1:0];
  end

  // Work buffer write on the last k of each (i,j).
  for (genvar e = 0; e < N*N; e++) begin : g_work
    assign work_d[e*OW +: OW] =
      (k_q == LAST && i_q == IW'(e / N) && j_q == IW'(e % N)) ? elem : work_q[e*OW +: OW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      res_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mm.start) begin
            a_q     <= mm.a;
            b_q     <= mm.b;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          if (mm.abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q  <= acc_d;
            work_q <= work_d;
            // k innermost, then j, then i.
            if (k_q == LAST) begin
              k_q <= '0;
              if (j_q == LAST) begin
                j_q <= '0;
                if (i_q == LAST) begin
                  i_q     <= '0;
                  state_q <= S_DONE;
                end else begin
                  i_q <= i_q + 1'b1;
                end
              end else begin
                j_q <= j_q + 1'b1;
              end
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          res_q   <= work_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mm.busy = busy_q;
  assign mm.done = done_q;
  assign mm.res  = res_q;

endmodule
